// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the RV32 pipeline: ALUOp encodings produced by
// decode, the 4-bit ALU operation codes the ALU control unit emits, and the
// packed record that travels through the ID/EX pipeline register.
// No ports; import with "import riscv_pkg::*;".
// ---------------------------------------------------------------------------
package riscv_pkg;

    // Natural datapath width of the core. The ID/EX record is sized from it.
    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // ALUOp classes coming out of the main decoder
    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    // Operation codes driven into the ALU by the ALU control unit
    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_SLL  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_SRA  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_ctrl_e;

    // Everything the ID/EX register captures from decode
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [1:0]      alu_op;
        logic [6:0]      funct7;
        logic [2:0]      funct3;
        reg_idx_t        rs1;
        reg_idx_t        rs2;
        reg_idx_t        rd;
        logic [XLEN-1:0] rd1_data;
        logic [XLEN-1:0] rd2_data;
        logic [XLEN-1:0] imm;
        logic            alu_src;
        logic            mem_read;
        logic            mem_write;
        logic            reg_write;
        logic            mem_to_reg;
        logic            branch;
    } id_ex_t;

    // A bubble is an all-zero record: not valid, no side effects, ALUOp MEM.
    localparam id_ex_t ID_EX_BUBBLE = '0;

endpackage

// File: rtl/hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
// Combinational load-use hazard detector. A load sitting in EX whose
// destination is read by the instruction in ID cannot forward in time, so
// one bubble is needed.
// Inputs : ex_valid, ex_mem_read, ex_rd  - instruction currently in EX
//          id_valid, id_rs1, id_rs2      - instruction currently in ID
//          ex_flush, reset               - suppress the stall request
// Outputs: stall                         - freeze PC and IF/ID, insert bubble
// ---------------------------------------------------------------------------
module hazard_detect
    import riscv_pkg::*;
(
    input  logic     ex_valid,
    input  logic     ex_mem_read,
    input  reg_idx_t ex_rd,
    input  logic     id_valid,
    input  reg_idx_t id_rs1,
    input  reg_idx_t id_rs2,
    input  logic     ex_flush,
    input  logic     reset,
    output logic     stall
);

    logic load_use;

    // x0 never carries a real dependency, so a load to x0 is ignored. A
    // flush squashes the ID instruction anyway and reset discards the whole
    // pipe, so neither should freeze the front end.
    always_comb begin
        load_use = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid &&
                   ((ex_rd == id_rs1) || (ex_rd == id_rs2));
        stall    = load_use && !ex_flush && !reset;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with load-use bubble insertion.
// Inputs : clk, reset (sync, active-high)
//          id_*        - decoded instruction fields and controls
//          ex_flush    - branch/jump resolved taken in EX, squash ID
//          hold        - downstream freeze, keep everything as is
// Outputs: ex_*        - registered copy of the id_* fields
//          stall       - load-use hazard, freezes PC and IF/ID
//          bubble_count- number of load-use bubbles inserted (wraps)
// The pipeline record is stored as riscv_pkg::id_ex_t; data fields are
// resized between DATA_W and the package XLEN at the boundary.
// ---------------------------------------------------------------------------
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int DATA_W = XLEN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [1:0]        id_alu_op,
    input  logic [6:0]        id_funct7,
    input  logic [2:0]        id_funct3,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [DATA_W-1:0] id_rd1_data,
    input  logic [DATA_W-1:0] id_rd2_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_alu_src,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_reg_write,
    input  logic              id_mem_to_reg,
    input  logic              id_branch,
    input  logic              ex_flush,
    input  logic              hold,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc,
    output logic [1:0]        ex_alu_op,
    output logic [6:0]        ex_funct7,
    output logic [2:0]        ex_funct3,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [DATA_W-1:0] ex_rd1_data,
    output logic [DATA_W-1:0] ex_rd2_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic              ex_alu_src,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_reg_write,
    output logic              ex_mem_to_reg,
    output logic              ex_branch,
    output logic              stall,
    output logic [15:0]       bubble_count
);

    id_ex_t      ex_q, ex_d;
    logic [15:0] bubble_count_q, bubble_count_d;
    logic        load_use_stall;

    hazard_detect u_hazard_detect (
        .ex_valid    (ex_q.valid),
        .ex_mem_read (ex_q.mem_read),
        .ex_rd       (ex_q.rd),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .ex_flush    (ex_flush),
        .reset       (reset),
        .stall       (load_use_stall)
    );

    // Next-state selection. Flush beats hold so a taken branch is never
    // followed by a wrong-path instruction, even if the back end is frozen.
    // Hold beats the bubble so a hazard seen while frozen is simply kept
    // pending and resolved on the first unfrozen edge. rd of 0 with
    // reg_write set is copied as-is; writeback drops writes to x0.
    always_comb begin
        ex_d           = ex_q;
        bubble_count_d = bubble_count_q;
        if (ex_flush) begin
            ex_d = ID_EX_BUBBLE;
        end else if (!hold) begin
            if (load_use_stall) begin
                ex_d           = ID_EX_BUBBLE;
                bubble_count_d = bubble_count_q + 16'd1;
            end else begin
                ex_d.valid      = id_valid;
                ex_d.pc         = XLEN'(id_pc);
                ex_d.alu_op     = id_alu_op;
                ex_d.funct7     = id_funct7;
                ex_d.funct3     = id_funct3;
                ex_d.rs1        = id_rs1;
                ex_d.rs2        = id_rs2;
                ex_d.rd         = id_rd;
                ex_d.rd1_data   = XLEN'(id_rd1_data);
                ex_d.rd2_data   = XLEN'(id_rd2_data);
                ex_d.imm        = XLEN'(id_imm);
                ex_d.alu_src    = id_alu_src;
                ex_d.mem_read   = id_mem_read;
                ex_d.mem_write  = id_mem_write;
                ex_d.reg_write  = id_reg_write;
                ex_d.mem_to_reg = id_mem_to_reg;
                ex_d.branch     = id_branch;
            end
        end
    end

    // Pipeline register and bubble counter; reset loads a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q           <= ID_EX_BUBBLE;
            bubble_count_q <= '0;
        end else begin
            ex_q           <= ex_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign ex_valid      = ex_q.valid;
    assign ex_pc         = DATA_W'(ex_q.pc);
    assign ex_alu_op     = ex_q.alu_op;
    assign ex_funct7     = ex_q.funct7;
    assign ex_funct3     = ex_q.funct3;
    assign ex_rs1        = ex_q.rs1;
    assign ex_rs2        = ex_q.rs2;
    assign ex_rd         = ex_q.rd;
    assign ex_rd1_data   = DATA_W'(ex_q.rd1_data);
    assign ex_rd2_data   = DATA_W'(ex_q.rd2_data);
    assign ex_imm        = DATA_W'(ex_q.imm);
    assign ex_alu_src    = ex_q.alu_src;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_to_reg = ex_q.mem_to_reg;
    assign ex_branch     = ex_q.branch;
    assign stall         = load_use_stall;
    assign bubble_count  = bubble_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
// Scoreboard bench for id_ex_stage. The stimulus process drives one cycle of
// inputs per clock, predicts the stage's response from a record-level model
// and queues it; the monitor pops one prediction per clock and compares.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          id_valid;
    logic [DW-1:0] id_pc;
    logic [1:0]    id_alu_op;
    logic [6:0]    id_funct7;
    logic [2:0]    id_funct3;
    logic [4:0]    id_rs1, id_rs2, id_rd;
    logic [DW-1:0] id_rd1_data, id_rd2_data, id_imm;
    logic          id_alu_src, id_mem_read, id_mem_write;
    logic          id_reg_write, id_mem_to_reg, id_branch;
    logic          ex_flush, hold;
    logic          ex_valid;
    logic [DW-1:0] ex_pc;
    logic [1:0]    ex_alu_op;
    logic [6:0]    ex_funct7;
    logic [2:0]    ex_funct3;
    logic [4:0]    ex_rs1, ex_rs2, ex_rd;
    logic [DW-1:0] ex_rd1_data, ex_rd2_data, ex_imm;
    logic          ex_alu_src, ex_mem_read, ex_mem_write;
    logic          ex_reg_write, ex_mem_to_reg, ex_branch;
    logic          stall;
    logic [15:0]   bubble_count;

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] pc;
        logic [1:0]    alu_op;
        logic [6:0]    funct7;
        logic [2:0]    funct3;
        logic [4:0]    rs1, rs2, rd;
        logic [DW-1:0] rd1, rd2, imm;
        logic          alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch;
    } ex_rec_t;

    typedef struct packed {
        ex_rec_t instr;
        logic    flush;
        logic    hold;
        logic    rst;
    } stim_t;

    typedef struct {
        logic    stall;
        ex_rec_t rec;
        int      count;
    } exp_t;

    exp_t    sb_q[$];
    ex_rec_t model_ex;
    int      model_count;
    int      n_compared   = 0;
    int      n_mismatched = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_pc(id_pc), .id_alu_op(id_alu_op),
        .id_funct7(id_funct7), .id_funct3(id_funct3),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rd1_data(id_rd1_data), .id_rd2_data(id_rd2_data), .id_imm(id_imm),
        .id_alu_src(id_alu_src), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
        .ex_flush(ex_flush), .hold(hold),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_alu_op(ex_alu_op),
        .ex_funct7(ex_funct7), .ex_funct3(ex_funct3),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_rd1_data(ex_rd1_data), .ex_rd2_data(ex_rd2_data), .ex_imm(ex_imm),
        .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch),
        .stall(stall), .bubble_count(bubble_count)
    );

    // Gather the EX-side outputs into one record for comparison
    function automatic ex_rec_t actualRec();
        ex_rec_t r;
        r.valid      = ex_valid;
        r.pc         = ex_pc;
        r.alu_op     = ex_alu_op;
        r.funct7     = ex_funct7;
        r.funct3     = ex_funct3;
        r.rs1        = ex_rs1;
        r.rs2        = ex_rs2;
        r.rd         = ex_rd;
        r.rd1        = ex_rd1_data;
        r.rd2        = ex_rd2_data;
        r.imm        = ex_imm;
        r.alu_src    = ex_alu_src;
        r.mem_read   = ex_mem_read;
        r.mem_write  = ex_mem_write;
        r.reg_write  = ex_reg_write;
        r.mem_to_reg = ex_mem_to_reg;
        r.branch     = ex_branch;
        return r;
    endfunction

    function automatic ex_rec_t randInstr();
        ex_rec_t r;
        r.valid      = ($urandom_range(0, 7) != 0);
        r.pc         = $urandom;
        r.alu_op     = 2'($urandom_range(0, 3));
        r.funct7     = 7'($urandom);
        r.funct3     = 3'($urandom);
        r.rs1        = 5'($urandom_range(0, 3));
        r.rs2        = 5'($urandom_range(0, 3));
        r.rd         = 5'($urandom_range(0, 3));
        r.rd1        = $urandom;
        r.rd2        = $urandom;
        r.imm        = $urandom;
        r.alu_src    = 1'($urandom);
        r.mem_read   = 1'($urandom);
        r.mem_write  = 1'($urandom);
        r.reg_write  = 1'($urandom);
        r.mem_to_reg = 1'($urandom);
        r.branch     = 1'($urandom);
        return r;
    endfunction

    task automatic driveInputs(input stim_t s);
        reset         = s.rst;
        ex_flush      = s.flush;
        hold          = s.hold;
        id_valid      = s.instr.valid;
        id_pc         = s.instr.pc;
        id_alu_op     = s.instr.alu_op;
        id_funct7     = s.instr.funct7;
        id_funct3     = s.instr.funct3;
        id_rs1        = s.instr.rs1;
        id_rs2        = s.instr.rs2;
        id_rd         = s.instr.rd;
        id_rd1_data   = s.instr.rd1;
        id_rd2_data   = s.instr.rd2;
        id_imm        = s.instr.imm;
        id_alu_src    = s.instr.alu_src;
        id_mem_read   = s.instr.mem_read;
        id_mem_write  = s.instr.mem_write;
        id_reg_write  = s.instr.reg_write;
        id_mem_to_reg = s.instr.mem_to_reg;
        id_branch     = s.instr.branch;
    endtask

    // Drive one cycle, predict stall for this cycle and the EX contents and
    // bubble count after the coming edge, and queue the prediction. With
    // preload set, the counter's next value is forced to 16'hFFFF for that
    // one edge so the wrap can be reached quickly.
    task automatic applyStimulus(input stim_t s, input bit preload);
        exp_t e;
        bit   hazard;
        @(negedge clk);
        #1;
        driveInputs(s);
        hazard = model_ex.valid && model_ex.mem_read && (model_ex.rd != 5'd0) &&
                 s.instr.valid && ((model_ex.rd == s.instr.rs1) || (model_ex.rd == s.instr.rs2));
        e.stall = hazard && !s.flush && !s.rst;
        if (s.rst) begin
            model_ex    = '0;
            model_count = 0;
        end else if (s.flush) begin
            model_ex = '0;
        end else if (!s.hold) begin
            if (hazard) begin
                model_ex    = '0;
                model_count = (model_count + 1) % 65536;
            end else begin
                model_ex = s.instr;
            end
        end
        if (preload) model_count = 65535;
        e.rec   = model_ex;
        e.count = model_count;
        sb_q.push_back(e);
        if (preload) begin
            force dut.bubble_count_d = 16'hFFFF;
            @(posedge clk);
            #1;
            release dut.bubble_count_d;
        end
    endtask

    task automatic checkOutput(input string what, input logic [199:0] act, input logic [199:0] expv);
        n_compared++;
        if (act !== expv) begin
            n_mismatched++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", what, $time, act, expv);
        end
    endtask

    // Monitor: stall is sampled just before the edge it influences, the
    // registered outputs just after it.
    initial begin : monitor
        logic sampled_stall;
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            sampled_stall = stall;
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checkOutput("stall", 200'(sampled_stall), 200'(e.stall));
                checkOutput("ex_regs", 200'(actualRec()), 200'(e.rec));
                checkOutput("bubble_count", 200'(bubble_count), 200'(e.count));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        stim_t s;
        stim_t dep;
        model_ex    = '0;
        model_count = 0;
        s           = '0;
        s.rst       = 1'b1;
        driveInputs(s);

        $display("[TB] reset with a live instruction in decode");
        s                 = '0;
        s.rst             = 1'b1;
        s.instr           = randInstr();
        s.instr.valid     = 1'b1;
        s.instr.reg_write = 1'b1;
        applyStimulus(s, 0);
        applyStimulus(s, 0);

        $display("[TB] plain capture of an R-type sub");
        s                 = '0;
        s.instr.valid     = 1'b1;
        s.instr.pc        = 32'h0000_0100;
        s.instr.alu_op    = 2'b10;
        s.instr.funct7    = 7'b0100000;
        s.instr.funct3    = 3'b000;
        s.instr.rs1       = 5'd1;
        s.instr.rs2       = 5'd2;
        s.instr.rd        = 5'd5;
        s.instr.rd1       = 32'd7;
        s.instr.rd2       = 32'd3;
        s.instr.reg_write = 1'b1;
        applyStimulus(s, 0);

        $display("[TB] load-use: lw x6 then add using x6");
        s                  = '0;
        s.instr.valid      = 1'b1;
        s.instr.pc         = 32'h0000_0104;
        s.instr.rs1        = 5'd2;
        s.instr.rd         = 5'd6;
        s.instr.imm        = 32'd8;
        s.instr.alu_src    = 1'b1;
        s.instr.mem_read   = 1'b1;
        s.instr.mem_to_reg = 1'b1;
        s.instr.reg_write  = 1'b1;
        applyStimulus(s, 0);
        dep                 = '0;
        dep.instr.valid     = 1'b1;
        dep.instr.pc        = 32'h0000_0108;
        dep.instr.alu_op    = 2'b10;
        dep.instr.rs1       = 5'd6;
        dep.instr.rs2       = 5'd7;
        dep.instr.rd        = 5'd8;
        dep.instr.reg_write = 1'b1;
        applyStimulus(dep, 0);
        applyStimulus(dep, 0);

        $display("[TB] no false hazard: load to x0, store with rd field");
        s.instr.rd = 5'd0;
        applyStimulus(s, 0);
        dep.instr.rs1 = 5'd0;
        dep.instr.rs2 = 5'd0;
        applyStimulus(dep, 0);
        s.instr.rd         = 5'd6;
        s.instr.mem_read   = 1'b0;
        s.instr.mem_to_reg = 1'b0;
        s.instr.reg_write  = 1'b0;
        s.instr.mem_write  = 1'b1;
        applyStimulus(s, 0);
        dep.instr.rs1 = 5'd1;
        dep.instr.rs2 = 5'd6;
        applyStimulus(dep, 0);

        $display("[TB] flush beats hold and hazard");
        s.instr.mem_read  = 1'b1;
        s.instr.mem_write = 1'b0;
        applyStimulus(s, 0);
        dep.instr.rs1 = 5'd6;
        dep.flush     = 1'b1;
        dep.hold      = 1'b1;
        applyStimulus(dep, 0);
        dep.flush = 1'b0;
        dep.hold  = 1'b0;
        applyStimulus(dep, 0);

        $display("[TB] hold freezes, including a pending hazard");
        for (int i = 0; i < 3; i++) begin
            s       = '0;
            s.instr = randInstr();
            s.hold  = 1'b1;
            applyStimulus(s, 0);
        end
        s                = '0;
        s.instr.valid    = 1'b1;
        s.instr.rd       = 5'd9;
        s.instr.mem_read = 1'b1;
        applyStimulus(s, 0);
        dep.instr.rs1 = 5'd3;
        dep.instr.rs2 = 5'd9;
        dep.hold      = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(dep, 0);
        dep.hold = 1'b0;
        applyStimulus(dep, 0);
        applyStimulus(dep, 0);

        $display("[TB] x0 destination with reg_write passes through");
        s                 = '0;
        s.instr.valid     = 1'b1;
        s.instr.rd        = 5'd0;
        s.instr.reg_write = 1'b1;
        s.instr.alu_op    = 2'b11;
        s.instr.imm       = 32'hFFFF_F800;
        applyStimulus(s, 0);

        $display("[TB] bubble counter wrap");
        s = '0;
        applyStimulus(s, 1);
        s                = '0;
        s.instr.valid    = 1'b1;
        s.instr.rd       = 5'd4;
        s.instr.mem_read = 1'b1;
        applyStimulus(s, 0);
        dep.instr.rs1 = 5'd4;
        dep.instr.rs2 = 5'd0;
        applyStimulus(dep, 0);
        applyStimulus(dep, 0);

        $display("[TB] reset during a stall");
        s.instr.rd = 5'd7;
        applyStimulus(s, 0);
        dep.instr.rs1 = 5'd7;
        dep.rst       = 1'b1;
        applyStimulus(dep, 0);
        dep.rst = 1'b0;
        applyStimulus(dep, 0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 600; i++) begin
            s       = '0;
            s.instr = randInstr();
            s.flush = ($urandom_range(0, 15) == 0);
            s.hold  = ($urandom_range(0, 7) == 0);
            s.rst   = ($urandom_range(0, 63) == 0);
            applyStimulus(s, 0);
        end

        repeat (3) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
